accum_amt_feeder: RTL and testbench

//   Upstream stage of the accumulator. Accepts a valid/ready stream of amounts,

---
 rtl/accum_pkg.sv | 22 ++
 rtl/accum_amt_feeder_fifo.sv | 79 +++++++
 rtl/accum_amt_feeder.sv | 149 ++++++++++++++
 tb/tb_accum_amt_feeder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accum_pkg
//  Description : Shared types for the accumulator datapath: the amount type
//                used on the accumulator amt/sum path and the state encoding
//                of the amount feeder.
//  Revision    : 1.0  initial release
// ============================================================================
package accum_pkg;

  localparam int AMT_WIDTH = 32;

  typedef logic [AMT_WIDTH-1:0] amt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } feeder_state_e;

endpackage : accum_pkg
`default_nettype wire

// File: rtl/accum_amt_feeder_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : amt_fifo
//  Description : Synchronous FIFO holding buffered amounts. Registered read
//                and write pointers, registered occupancy count, and a
//                synchronous clear that empties the FIFO in one cycle.
//  Ports       : clk, reset   - clock / synchronous active-high reset
//                clear        - empty the FIFO (wins over push/pop)
//                push, din    - write din at the tail (ignored when full)
//                pop          - drop the head entry (ignored when empty)
//                head         - current head entry (valid when !empty)
//                count        - occupancy 0..DEPTH
//                full, empty  - occupancy flags derived from count
//  Revision    : 1.0  initial release
// ============================================================================
module amt_fifo
  import accum_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == C_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage has no reset: contents are only observable through count.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : amt_fifo
`default_nettype wire

// File: rtl/accum_amt_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : accum_amt_feeder
//  Description : Upstream stage of the accumulator. Buffers a valid/ready
//                stream of amounts and releases at most one per clock onto
//                amt under start/stop/flush control. amt is 0 in every cycle
//                without a release so the accumulator may add unconditionally.
//  Config      : AMT_SAT_EN - when defined, amounts above SAT_MAX are clamped
//                before buffering and sat_hit records the first clamp.
//  Ports       : clk, reset          - clock / synchronous active-high reset
//                s_valid/s_ready/s_data - upstream amount stream
//                start, stop, flush  - control (priority flush > stop > start)
//                amt, amt_valid      - registered release to the accumulator
//                count               - FIFO occupancy
//                words_out           - total releases since reset (wraps)
//                sat_hit             - sticky clamp indicator
//  Revision    : 1.0  initial release
// ============================================================================
module accum_amt_feeder
  import accum_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               DEPTH   = 8,
  parameter logic [WIDTH-1:0] SAT_MAX = 32'h0000FFFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_data,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           amt,
  output logic                       amt_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [31:0]                words_out,
  output logic                       sat_hit
);

  feeder_state_e    state;
  feeder_state_e    state_next;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_clear;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] fifo_din;
  logic [WIDTH-1:0] fifo_head;

  // ---------------------------------------------------------------------------
  // Handshake and release qualification
  // ---------------------------------------------------------------------------
  assign s_ready    = !fifo_full && !flush && (state != FLUSH);
  assign push       = s_valid && s_ready;
  // Pop looks only at the registered occupancy, so an entry pushed this
  // cycle can never be released in the same cycle.
  assign pop        = (state == RUN) && !stop && !flush && !fifo_empty;
  assign fifo_clear = (state == FLUSH);

  // ---------------------------------------------------------------------------
  // Optional input clamp
  // ---------------------------------------------------------------------------
`ifdef AMT_SAT_EN
  logic clamp;

  assign clamp    = (s_data > SAT_MAX);
  assign fifo_din = clamp ? SAT_MAX : s_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_hit <= 1'b0;
    end else if (push && clamp) begin
      sat_hit <= 1'b1;
    end
  end
`else
  logic unused_sat_max;

  assign unused_sat_max = ^SAT_MAX;
  assign fifo_din       = s_data;
  assign sat_hit        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Buffer
  // ---------------------------------------------------------------------------
  amt_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (fifo_clear),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .head  (fifo_head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = FLUSH;
    end else begin
      case (state)
        IDLE:    if (start) state_next = RUN;
        RUN:     if (stop)  state_next = IDLE;
        FLUSH:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      amt       <= '0;
      amt_valid <= 1'b0;
      words_out <= '0;
    end else if (pop) begin
      amt       <= fifo_head;
      amt_valid <= 1'b1;
      words_out <= words_out + 32'd1;
    end else begin
      amt       <= '0;
      amt_valid <= 1'b0;
    end
  end

endmodule : accum_amt_feeder
`default_nettype wire

// File: tb/tb_accum_amt_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accum_amt_feeder
//  Description : Directed self-checking bench for accum_amt_feeder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_accum_amt_feeder;
  import accum_pkg::*;

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  amt_t        s_data;
  logic        start;
  logic        stop;
  logic        flush;
  amt_t        amt;
  logic        amt_valid;
  logic [3:0]  count;
  logic [31:0] words_out;
  logic        sat_hit;

  int errors = 0;
  int checks = 0;

  accum_amt_feeder #(
    .WIDTH   (32),
    .DEPTH   (8),
    .SAT_MAX (32'h0000FFFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .start     (start),
    .stop      (stop),
    .flush     (flush),
    .amt       (amt),
    .amt_valid (amt_valid),
    .count     (count),
    .words_out (words_out),
    .sat_hit   (sat_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    start   = 1'b0;
    stop    = 1'b0;
    flush   = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_amt",       amt,       32'd0);
    check("rst_amt_valid", amt_valid, 32'd0);
    check("rst_count",     count,     32'd0);
    check("rst_words",     words_out, 32'd0);
    check("rst_sat",       sat_hit,   32'd0);
    check("rst_s_ready",   s_ready,   32'd1);

    // 1: push 5,7,9 in IDLE, then start
    s_valid = 1'b1; s_data = 32'd5; tick();
    s_data = 32'd7; tick();
    s_data = 32'd9; tick();
    s_valid = 1'b0;
    check("t1_count3", count, 32'd3);
    check("t1_idle_amt", amt_valid, 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("t1_no_pop_yet", amt_valid, 32'd0);
    tick(); check("t1_amt5", amt, 32'd5); check("t1_valid", amt_valid, 32'd1);
    tick(); check("t1_amt7", amt, 32'd7);
    tick(); check("t1_amt9", amt, 32'd9);
    tick();
    check("t1_amt0",   amt,       32'd0);
    check("t1_vld0",   amt_valid, 32'd0);
    check("t1_words",  words_out, 32'd3);
    check("t1_count0", count,     32'd0);
    stop = 1'b1; tick(); stop = 1'b0;

    // 2: fill to 8, hold a 9th, then drain
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = 32'h10 + i; tick();
    end
    s_data = 32'h99;
    check("t2_count8", count,   32'd8);
    check("t2_full",   s_ready, 32'd0);
    tick();
    check("t2_held", count, 32'd8);
    start = 1'b1; tick(); start = 1'b0;
    check("t2_no_pop_yet", amt_valid, 32'd0);
    for (int k = 0; k < 9; k++) begin
      tick();
      check("t2_amt", amt, (k < 8) ? 32'h10 + k : 32'h99);
      if (k == 1) s_valid = 1'b0;
    end
    tick();
    check("t2_amt0",   amt,       32'd0);
    check("t2_count0", count,     32'd0);
    check("t2_words",  words_out, 32'd12);
    stop = 1'b1; tick(); stop = 1'b0;

    // 3: stop after two pops, resume later
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 32'h21 + i; tick();
    end
    s_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); check("t3_amt21", amt, 32'h21);
    tick(); check("t3_amt22", amt, 32'h22);
    stop = 1'b1; tick(); stop = 1'b0;
    check("t3_stop_amt",   amt,       32'd0);
    check("t3_stop_vld",   amt_valid, 32'd0);
    check("t3_stop_count", count,     32'd2);
    tick();
    check("t3_idle_amt", amt, 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    tick(); check("t3_amt23", amt, 32'h23);
    tick(); check("t3_amt24", amt, 32'h24);
    tick(); check("t3_words", words_out, 32'd16);
    stop = 1'b1; tick(); stop = 1'b0;

    // 4: flush with s_valid while count=4
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 32'h31 + i; tick();
    end
    check("t4_count4", count, 32'd4);
    s_data = 32'h55; flush = 1'b1;
    #1;
    check("t4_ready_flush", s_ready, 32'd0);
    tick();
    flush = 1'b0; s_valid = 1'b0;
    check("t4_ready_in_flush", s_ready, 32'd0);
    tick();
    check("t4_count0", count,   32'd0);
    check("t4_amt0",   amt,     32'd0);
    check("t4_ready",  s_ready, 32'd1);
    s_valid = 1'b1; s_data = 32'h66; tick(); s_valid = 1'b0;
    tick();
    check("t4_idle_no_pop", amt_valid, 32'd0);
    check("t4_idle_count",  count,     32'd1);

    // 5: reset while in RUN with 3 buffered entries
    s_valid = 1'b1; s_data = 32'h41; tick();
    s_data = 32'h42; tick();
    s_valid = 1'b0;
    check("t5_count3", count, 32'd3);
    start = 1'b1; tick(); start = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("t5_amt",   amt,       32'd0);
    check("t5_vld",   amt_valid, 32'd0);
    check("t5_count", count,     32'd0);
    check("t5_words", words_out, 32'd0);
    check("t5_sat",   sat_hit,   32'd0);
    tick(); tick();
    check("t5_no_stale", amt_valid, 32'd0);
    s_valid = 1'b1; s_data = 32'h77; tick(); s_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("t5_fresh_amt", amt,       32'h77);
    check("t5_words1",    words_out, 32'd1);

    // 6: clamp behaviour, push into empty FIFO while in RUN
    s_valid = 1'b1; s_data = 32'h00012345; tick(); s_valid = 1'b0;
    check("t6_no_bypass", amt_valid, 32'd0);
    check("t6_count1",    count,     32'd1);
    tick();
    check("t6_vld", amt_valid, 32'd1);
`ifdef AMT_SAT_EN
    check("t6_amt", amt,     32'h0000FFFF);
    check("t6_sat", sat_hit, 32'd1);
    tick();
    check("t6_sat_sticky", sat_hit, 32'd1);
`else
    check("t6_amt", amt,     32'h00012345);
    check("t6_sat", sat_hit, 32'd0);
    tick();
    check("t6_sat_low", sat_hit, 32'd0);
`endif
    check("t6_amt0", amt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_accum_amt_feeder
`default_nettype wire
